// File: rtl/hbm_edge_rd_responder.sv
// hbm_edge_rd_responder
//   Controller-side responder for one HBM pseudo-channel edge read path.
//   Edge-word read requests are queued in a small FIFO. Each entry is issued as
//   a single-beat AXI4 read. Returned words are forwarded in order, one cycle
//   after the R beat.
//
//   Optional feature macro: HBM_RD_PERF_EN
//     When defined, adds rd_req_cnt (AR handshakes) and rd_rsp_cnt (R beats
//     forwarded). Both are saturating 32-bit counters.
//
// Ports
//   clk                   clock
//   rst                   synchronous reset, active low
//   rd_hbm_edge_addr      edge-word index of a request
//   rd_hbm_edge_valid     request strobe (no ready; always taken or dropped)
//   hbm_controller_full   registered backpressure to the request sender
//   hbm_controller_edge   returned edge word
//   hbm_controller_valid  one-cycle qualifier for hbm_controller_edge
//   m_axi_ar*             AXI4 read-address channel (single beat, ID 0)
//   m_axi_r*              AXI4 read-data channel (rready tied high)
//   err_overflow          sticky: a request was dropped because the FIFO was full
//   rd_req_cnt/rd_rsp_cnt performance counters (HBM_RD_PERF_EN only)
//
// AR FSM
//   state   | meaning
//   ST_IDLE | no AR presented; pops the FIFO when there is an entry and credit
//   ST_ADDR | AR presented and held until arready; can chain 1 AR per cycle
module hbm_edge_rd_responder #(
  parameter int                    HBM_AWIDTH      = 32,
  parameter int                    HBM_DWIDTH      = 512,
  parameter int                    AXI_AWIDTH      = 33,
  parameter logic [AXI_AWIDTH-1:0] HBM_BASE_ADDR   = '0,
  parameter int                    REQ_FIFO_DEPTH  = 16,
  parameter int                    FULL_THRESH     = 12,
  parameter int                    MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HBM_AWIDTH-1:0] rd_hbm_edge_addr,
  input  logic                  rd_hbm_edge_valid,
  output logic                  hbm_controller_full,
  output logic [HBM_DWIDTH-1:0] hbm_controller_edge,
  output logic                  hbm_controller_valid,
  output logic [AXI_AWIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [HBM_DWIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  input  logic                  m_axi_rlast,
  output logic                  m_axi_rready,
  output logic                  err_overflow
`ifdef HBM_RD_PERF_EN
  ,
  output logic [31:0]           rd_req_cnt,
  output logic [31:0]           rd_rsp_cnt
`endif
);

  localparam int PTR_W      = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_SHIFT = $clog2(HBM_DWIDTH / 8);

  localparam logic [CNT_W-1:0] FIFO_DEPTH_C  = CNT_W'(REQ_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_THRESH_C = CNT_W'(FULL_THRESH);
  localparam logic [OUT_W-1:0] MAX_OUT_C     = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic {ST_IDLE, ST_ADDR} state_t;

  state_t                  state_q, state_d;
  logic [HBM_AWIDTH-1:0]   fifo_mem [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_cnt, fifo_cnt_next;
  logic [OUT_W-1:0]        out_cnt, out_cnt_next;
  logic                    fifo_empty, fifo_full;
  logic                    push, pop, ar_hs, r_done, arvalid_d;
  logic [AXI_AWIDTH-1:0]   head_addr, araddr_calc;

  assign m_axi_arlen  = 8'd0;
  assign m_axi_arsize = 3'(BEAT_SHIFT);
  assign m_axi_rready = 1'b1;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_DEPTH_C);
  assign ar_hs      = m_axi_arvalid & m_axi_arready;
  // An R beat with nothing outstanding is a protocol error; it must not underflow the credit count.
  assign r_done     = m_axi_rvalid & m_axi_rready & m_axi_rlast & (out_cnt != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = rd_hbm_edge_valid & (~fifo_full | pop);

  // Carry beyond AXI_AWIDTH is intentionally discarded.
  assign head_addr   = AXI_AWIDTH'(fifo_mem[rd_ptr]);
  assign araddr_calc = HBM_BASE_ADDR + (head_addr << BEAT_SHIFT);

  always_comb begin
    out_cnt_next = out_cnt;
    case ({ar_hs, r_done})
      2'b10:   out_cnt_next = out_cnt + OUT_W'(1);
      2'b01:   out_cnt_next = out_cnt - OUT_W'(1);
      default: out_cnt_next = out_cnt;
    endcase
  end

  always_comb begin
    fifo_cnt_next = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_next = fifo_cnt + CNT_W'(1);
      2'b01:   fifo_cnt_next = fifo_cnt - CNT_W'(1);
      default: fifo_cnt_next = fifo_cnt;
    endcase
  end

  // Pop only looks at the registered occupancy, so a word pushed this cycle is never popped this cycle.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    arvalid_d = m_axi_arvalid;
    case (state_q)
      ST_IDLE: begin
        arvalid_d = 1'b0;
        if (!fifo_empty && (out_cnt < MAX_OUT_C)) begin
          pop       = 1'b1;
          arvalid_d = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_hs) begin
          // The handshaking AR is counted in out_cnt_next, so chaining cannot exceed the credit limit.
          if (!fifo_empty && (out_cnt_next < MAX_OUT_C)) begin
            pop = 1'b1;
          end else begin
            arvalid_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        arvalid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_mem[wr_ptr] <= rd_hbm_edge_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q              <= ST_IDLE;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      fifo_cnt             <= '0;
      out_cnt              <= '0;
      m_axi_arvalid        <= 1'b0;
      m_axi_araddr         <= '0;
      hbm_controller_full  <= 1'b0;
      err_overflow         <= 1'b0;
      hbm_controller_edge  <= '0;
      hbm_controller_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_axi_arvalid <= arvalid_d;
      if (pop) begin
        m_axi_araddr <= araddr_calc;
        rd_ptr       <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      fifo_cnt            <= fifo_cnt_next;
      out_cnt             <= out_cnt_next;
      hbm_controller_full <= (fifo_cnt_next >= FULL_THRESH_C);
      if (rd_hbm_edge_valid && !push) begin
        err_overflow <= 1'b1;
      end
      if (m_axi_rvalid) begin
        hbm_controller_edge <= m_axi_rdata;
      end
      hbm_controller_valid <= m_axi_rvalid;
    end
  end

`ifdef HBM_RD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_req_cnt <= '0;
      rd_rsp_cnt <= '0;
    end else begin
      if (ar_hs && (rd_req_cnt != 32'hFFFF_FFFF)) begin
        rd_req_cnt <= rd_req_cnt + 32'd1;
      end
      if (m_axi_rvalid && (rd_rsp_cnt != 32'hFFFF_FFFF)) begin
        rd_rsp_cnt <= rd_rsp_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hbm_edge_rd_responder.sv
// Directed bench for hbm_edge_rd_responder. Expected AR addresses and returned
// edge words are queued when stimulus is driven and checked when the DUT
// produces them.
module tb_hbm_edge_rd_responder;
  localparam int AW  = 32;
  localparam int DW  = 512;
  localparam int XAW = 33;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [AW-1:0]  rd_hbm_edge_addr;
  logic           rd_hbm_edge_valid;
  logic           hbm_controller_full;
  logic [DW-1:0]  hbm_controller_edge;
  logic           hbm_controller_valid;
  logic [XAW-1:0] m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic           m_axi_arvalid;
  logic           m_axi_arready;
  logic [DW-1:0]  m_axi_rdata;
  logic           m_axi_rvalid;
  logic           m_axi_rlast;
  logic           m_axi_rready;
  logic           err_overflow;
`ifdef HBM_RD_PERF_EN
  logic [31:0]    rd_req_cnt;
  logic [31:0]    rd_rsp_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [XAW-1:0] araddr_q[$];
  logic [DW-1:0]  edge_q[$];

  hbm_edge_rd_responder dut (
    .clk                  (clk),
    .rst                  (rst),
    .rd_hbm_edge_addr     (rd_hbm_edge_addr),
    .rd_hbm_edge_valid    (rd_hbm_edge_valid),
    .hbm_controller_full  (hbm_controller_full),
    .hbm_controller_edge  (hbm_controller_edge),
    .hbm_controller_valid (hbm_controller_valid),
    .m_axi_araddr         (m_axi_araddr),
    .m_axi_arlen          (m_axi_arlen),
    .m_axi_arsize         (m_axi_arsize),
    .m_axi_arvalid        (m_axi_arvalid),
    .m_axi_arready        (m_axi_arready),
    .m_axi_rdata          (m_axi_rdata),
    .m_axi_rvalid         (m_axi_rvalid),
    .m_axi_rlast          (m_axi_rlast),
    .m_axi_rready         (m_axi_rready),
    .err_overflow         (err_overflow)
`ifdef HBM_RD_PERF_EN
    ,
    .rd_req_cnt           (rd_req_cnt),
    .rd_rsp_cnt           (rd_rsp_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XAW-1:0] araddr_of(input logic [AW-1:0] a);
    logic [XAW-1:0] w;
    w = XAW'(a);
    return w << 6;
  endfunction

  task automatic req(input logic [AW-1:0] a, input bit expect_issue);
    rd_hbm_edge_valid = 1'b1;
    rd_hbm_edge_addr  = a;
    if (expect_issue) araddr_q.push_back(araddr_of(a));
    tick();
    rd_hbm_edge_valid = 1'b0;
  endtask

  task automatic r_beat(input logic [DW-1:0] d);
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    m_axi_rdata  = d;
    edge_q.push_back(d);
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  // AR handshakes and forwarded words, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (m_axi_arvalid && m_axi_arready) begin
        if (araddr_q.size() == 0) chk("ar_unexpected", m_axi_arvalid, 0);
        else                      chk("araddr", m_axi_araddr, araddr_q.pop_front());
      end
      if (hbm_controller_valid) begin
        if (edge_q.size() == 0) chk("edge_unexpected", hbm_controller_valid, 0);
        else                    chk("edge", hbm_controller_edge, edge_q.pop_front());
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    rd_hbm_edge_valid = 1'b0;
    rd_hbm_edge_addr  = '0;
    m_axi_arready     = 1'b0;
    m_axi_rdata       = '0;
    m_axi_rvalid      = 1'b0;
    m_axi_rlast       = 1'b0;

    // reset values
    repeat (3) tick();
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_full", hbm_controller_full, 0);
    chk("rst_valid", hbm_controller_valid, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_rready", m_axi_rready, 1);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_arsize", m_axi_arsize, 6);
    rst = 1'b1;
    tick();

    // single request, R beat three cycles after the AR
    m_axi_arready = 1'b1;
    req(32'h10, 1'b1);
    chk("t1_arvalid_early", m_axi_arvalid, 0);
    tick();
    chk("t1_arvalid", m_axi_arvalid, 1);
    chk("t1_araddr", m_axi_araddr, 33'h400);
    tick();
    chk("t1_arvalid_drop", m_axi_arvalid, 0);
    tick();
    tick();
    d = {16{32'hA5A5_0001}};
    r_beat(d);
    chk("t1_valid", hbm_controller_valid, 1);
    chk("t1_edge", hbm_controller_edge, d);
    tick();
    chk("t1_valid_pulse", hbm_controller_valid, 0);

    // fill all 16 credits with back-to-back ARs
    for (int i = 0; i < 16; i++) req(32'h100 + i, 1'b1);
    repeat (4) tick();
    chk("t3_credits_exhausted", m_axi_arvalid, 0);

    // no credit left: FIFO fills without pops
    m_axi_arready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      req(32'h200 + k - 1, k <= 16);
      chk($sformatf("t2_full_%0d", k), hbm_controller_full, (k >= 12) ? 1 : 0);
      chk($sformatf("t2_err_%0d", k), err_overflow, (k >= 17) ? 1 : 0);
    end
    tick();
    tick();
    chk("t3_stalled", m_axi_arvalid, 0);
    r_beat({16{32'hBEEF_0002}});
    tick();
    chk("t3_reissue", m_axi_arvalid, 1);
    chk("t3_reissue_addr", m_axi_araddr, 33'h8000);

    // drain the FIFO one credit at a time, then bring outstanding to 5
    m_axi_arready = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      r_beat({16{32'hB000_0000 | i}});
      tick();
      tick();
    end
    for (int i = 0; i < 11; i++) r_beat({16{32'hC000_0000 | i}});

    // AR handshake and R-last in the same cycle at outstanding=5
    m_axi_arready = 1'b0;
    req(32'h300, 1'b1);
    tick();
    chk("t4_arvalid", m_axi_arvalid, 1);
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b1;
    m_axi_rlast   = 1'b1;
    m_axi_rdata   = {16{32'hD00D_0004}};
    edge_q.push_back(m_axi_rdata);
    tick();
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    for (int i = 0; i < 5; i++) r_beat({16{32'hE000_0000 | i}});
    // outstanding should be 0 now: exactly 16 of 17 requests may issue
    for (int i = 0; i < 17; i++) req(32'h400 + i, i < 16);
    repeat (4) tick();
    chk("t4_17th_blocked", m_axi_arvalid, 0);
    chk("t4_ar_count", araddr_q.size(), 0);

    // reset mid-burst with the FIFO above threshold and an R beat during reset
    m_axi_arready = 1'b0;
    for (int i = 0; i < 12; i++) req(32'h500 + i, 1'b0);
    chk("t5_full_before", hbm_controller_full, 1);
    rst          = 1'b0;
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    m_axi_rdata  = {16{32'hDEAD_DEAD}};
    tick();
    rst          = 1'b1;
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    araddr_q.delete();
    chk("t5_arvalid", m_axi_arvalid, 0);
    chk("t5_full", hbm_controller_full, 0);
    chk("t5_valid", hbm_controller_valid, 0);
    chk("t5_err", err_overflow, 0);
    m_axi_arready = 1'b1;
    repeat (3) tick();
    chk("t5_fifo_empty", m_axi_arvalid, 0);

    // eight requests and responses after reset
    for (int i = 0; i < 8; i++) req(32'h20 + i, 1'b1);
    repeat (3) tick();
    for (int i = 0; i < 8; i++) r_beat({16{32'hF000_0000 | i}});
    tick();
`ifdef HBM_RD_PERF_EN
    chk("t6_rd_req_cnt", rd_req_cnt, 8);
    chk("t6_rd_rsp_cnt", rd_rsp_cnt, 8);
`endif
    tick();
    chk("end_ar_queue", araddr_q.size(), 0);
    chk("end_edge_queue", edge_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
